// File: rtl/rob.sv
// rtl/rob.sv - reorder buffer: in-order allocate/retire, out-of-order completion, branch flush
// Circular entry store indexed by tag; full and empty are told apart by count alone.
module rob #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 4,
  parameter int PREG_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_valid,
  input  logic              alloc_has_rd,
  input  logic [PREG_W-1:0] alloc_pd_old,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              alu_done,
  input  logic [TAG_W-1:0]  alu_tag,
  input  logic              b_done,
  input  logic [TAG_W-1:0]  b_tag,
  input  logic              mem_done,
  input  logic [TAG_W-1:0]  mem_tag,
  input  logic              mispredict,
  input  logic [TAG_W-1:0]  mispredict_tag,
  output logic              retire_valid,
  output logic [TAG_W-1:0]  retire_tag,
  output logic              retire_has_rd,
  output logic [PREG_W-1:0] retire_pd_old,
  output logic [TAG_W-1:0]  curr_rob_tag,
  output logic [TAG_W:0]    count
);

  localparam logic [TAG_W:0]   DEPTH_C = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W-1:0] ONE_TAG = TAG_W'(1);

  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_done;
  logic [DEPTH-1:0]  r_has_rd;
  logic [PREG_W-1:0] r_pd_old [DEPTH];
  logic [TAG_W-1:0]  r_head;
  logic [TAG_W-1:0]  r_tail;
  logic [TAG_W:0]    r_count;

  logic              w_alloc_ready;
  logic              w_alloc;
  logic              w_retire;
  logic              w_flush;
  logic [TAG_W-1:0]  w_br_age;
  logic [DEPTH-1:0]  w_flush_mask;
  logic [TAG_W:0]    w_count_next;

  function automatic logic [TAG_W-1:0] age_of(input logic [TAG_W-1:0] idx,
                                              input logic [TAG_W-1:0] hd);
    return idx - hd;
  endfunction

  // A same-cycle retire deliberately does not free a slot for allocation.
  assign w_alloc_ready = !reset && (r_count < DEPTH_C) && !mispredict;
  assign w_alloc       = alloc_valid && w_alloc_ready;
  assign w_retire      = r_valid[r_head] && r_done[r_head];
  assign w_flush       = mispredict && r_valid[mispredict_tag];
  assign w_br_age      = age_of(mispredict_tag, r_head);

  always_comb begin
    w_flush_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_flush_mask[i] = w_flush && (age_of(TAG_W'(i), r_head) > w_br_age);
    end
  end

  always_comb begin
    w_count_next = r_count;
    if (w_flush) begin
      w_count_next = {1'b0, w_br_age} + (TAG_W+1)'(1) - (TAG_W+1)'(w_retire);
    end else begin
      w_count_next = r_count + (TAG_W+1)'(w_alloc) - (TAG_W+1)'(w_retire);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid  <= '0;
      r_done   <= '0;
      r_has_rd <= '0;
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pd_old[i] <= '0;
      end
    end else begin
      if (alu_done && r_valid[alu_tag]) r_done[alu_tag] <= 1'b1;
      if (b_done && r_valid[b_tag])     r_done[b_tag]   <= 1'b1;
      if (mem_done && r_valid[mem_tag]) r_done[mem_tag] <= 1'b1;
      // Flush is applied after completions so strobes to squashed entries are lost.
      for (int i = 0; i < DEPTH; i++) begin
        if (w_flush_mask[i]) begin
          r_valid[i] <= 1'b0;
          r_done[i]  <= 1'b0;
        end
      end
      if (w_retire) begin
        r_valid[r_head] <= 1'b0;
        r_done[r_head]  <= 1'b0;
        r_head          <= r_head + ONE_TAG;
      end
      if (w_alloc) begin
        r_valid[r_tail]  <= 1'b1;
        r_done[r_tail]   <= 1'b0;
        r_has_rd[r_tail] <= alloc_has_rd;
        r_pd_old[r_tail] <= alloc_pd_old;
      end
      if (w_flush) begin
        r_tail <= mispredict_tag + ONE_TAG;
      end else if (w_alloc) begin
        r_tail <= r_tail + ONE_TAG;
      end
      r_count <= w_count_next;
    end
  end

  assign alloc_ready   = w_alloc_ready;
  assign alloc_tag     = r_tail;
  assign retire_valid  = w_retire;
  assign retire_tag    = w_retire ? r_head : '0;
  assign retire_has_rd = w_retire ? r_has_rd[r_head] : 1'b0;
  assign retire_pd_old = w_retire ? r_pd_old[r_head] : '0;
  assign curr_rob_tag  = r_head;
  assign count         = r_count;

endmodule

// File: tb/tb_rob.sv
// tb/tb_rob.sv - directed self-checking bench for rob
module tb_rob;

  logic       clk = 1'b0;
  logic       reset;
  logic       alloc_valid;
  logic       alloc_has_rd;
  logic [6:0] alloc_pd_old;
  logic       alloc_ready;
  logic [3:0] alloc_tag;
  logic       alu_done, b_done, mem_done;
  logic [3:0] alu_tag, b_tag, mem_tag;
  logic       mispredict;
  logic [3:0] mispredict_tag;
  logic       retire_valid;
  logic [3:0] retire_tag;
  logic       retire_has_rd;
  logic [6:0] retire_pd_old;
  logic [3:0] curr_rob_tag;
  logic [4:0] count;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  rob #(.DEPTH(16), .TAG_W(4), .PREG_W(7)) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_has_rd(alloc_has_rd), .alloc_pd_old(alloc_pd_old),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .alu_done(alu_done), .alu_tag(alu_tag),
    .b_done(b_done), .b_tag(b_tag),
    .mem_done(mem_done), .mem_tag(mem_tag),
    .mispredict(mispredict), .mispredict_tag(mispredict_tag),
    .retire_valid(retire_valid), .retire_tag(retire_tag),
    .retire_has_rd(retire_has_rd), .retire_pd_old(retire_pd_old),
    .curr_rob_tag(curr_rob_tag), .count(count)
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    check("rst_pulse_count", count, 0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; alloc_valid = 0; alloc_has_rd = 0; alloc_pd_old = '0;
    alu_done = 0; b_done = 0; mem_done = 0; alu_tag = '0; b_tag = '0; mem_tag = '0;
    mispredict = 0; mispredict_tag = '0;
    #1 reset = 1'b1;
    #2;
    check("rst_count", count, 0);
    check("rst_alloc_ready", alloc_ready, 0);
    check("rst_retire_valid", retire_valid, 0);
    check("rst_alloc_tag", alloc_tag, 0);
    check("rst_head", curr_rob_tag, 0);
    check("rst_retire_tag", retire_tag, 0);
    check("rst_retire_has_rd", retire_has_rd, 0);
    check("rst_retire_pd_old", retire_pd_old, 0);
    #9 reset = 1'b0;

    // basic allocate, complete, retire
    alloc_valid = 1; alloc_has_rd = 1;
    for (int i = 0; i < 3; i++) begin
      alloc_pd_old = 7'(10 + i);
      #1 check("a3_tag", alloc_tag, i);
      check("a3_ready", alloc_ready, 1);
      tick();
    end
    alloc_valid = 0;
    #1 check("a3_count", count, 3);
    check("a3_no_retire", retire_valid, 0);
    alu_done = 1; alu_tag = 4'd0;
    #1 check("c0_same_cycle", retire_valid, 0);
    tick(); alu_done = 0;
    #1 check("c0_retire_valid", retire_valid, 1);
    check("c0_retire_tag", retire_tag, 0);
    check("c0_pd_old", retire_pd_old, 10);
    check("c0_has_rd", retire_has_rd, 1);
    tick();
    check("c0_count_after", count, 2);
    check("c0_head_after", curr_rob_tag, 1);
    b_done = 1; b_tag = 4'd2;
    tick(); b_done = 0;
    #1 check("ooo_wait_head", retire_valid, 0);
    mem_done = 1; mem_tag = 4'd1;
    tick(); mem_done = 0;
    #1 check("r1_tag", retire_tag, 1);
    check("r1_pd", retire_pd_old, 11);
    tick();
    check("r2_tag", retire_tag, 2);
    check("r2_pd", retire_pd_old, 12);
    tick();
    check("drain_valid", retire_valid, 0);
    check("drain_count", count, 0);
    check("drain_head", curr_rob_tag, 3);

    // out-of-order completion, oldest last
    alloc_valid = 1;
    for (int i = 0; i < 3; i++) begin
      alloc_pd_old = 7'(20 + i);
      #1 check("b3_tag", alloc_tag, 3 + i);
      tick();
    end
    alloc_valid = 0;
    b_done = 1; b_tag = 4'd5;
    tick(); b_done = 0;
    alu_done = 1; alu_tag = 4'd4;
    tick(); alu_done = 0;
    #1 check("ooo2_wait", retire_valid, 0);
    mem_done = 1; mem_tag = 4'd3;
    tick(); mem_done = 0;
    #1 check("ooo_r3_valid", retire_valid, 1);
    check("ooo_r3_tag", retire_tag, 3);
    check("ooo_r3_pd", retire_pd_old, 20);
    tick();
    check("ooo_r4_tag", retire_tag, 4);
    check("ooo_r4_pd", retire_pd_old, 21);
    tick();
    check("ooo_r5_tag", retire_tag, 5);
    check("ooo_r5_pd", retire_pd_old, 22);
    tick();
    check("ooo_end_valid", retire_valid, 0);
    check("ooo_end_count", count, 0);

    // fill to full, blocked, retire one, wrap
    pulse_reset();
    alloc_valid = 1;
    for (int i = 0; i < 16; i++) begin
      alloc_has_rd = i[0];
      alloc_pd_old = 7'(40 + i);
      #1 check("fill_tag", alloc_tag, i);
      check("fill_ready", alloc_ready, 1);
      tick();
    end
    #1 check("full_count", count, 16);
    check("full_ready", alloc_ready, 0);
    check("full_tail", alloc_tag, 0);
    check("full_head", curr_rob_tag, 0);
    tick();
    check("full_blocked_count", count, 16);
    alloc_valid = 0;
    alu_done = 1; alu_tag = 4'd0;
    tick(); alu_done = 0; alloc_valid = 1; alloc_pd_old = 7'd99;
    #1 check("full_retire_valid", retire_valid, 1);
    check("full_retire_pd", retire_pd_old, 40);
    check("full_retire_has_rd", retire_has_rd, 0);
    check("full_ready_no_relax", alloc_ready, 0);
    tick();
    check("after_ret_count", count, 15);
    check("after_ret_ready", alloc_ready, 1);
    check("wrap_alloc_tag", alloc_tag, 0);
    check("after_ret_head", curr_rob_tag, 1);
    tick(); alloc_valid = 0;
    #1 check("refill_count", count, 16);
    check("refill_tail", alloc_tag, 1);

    // mispredict flush
    pulse_reset();
    alloc_valid = 1; alloc_has_rd = 1;
    for (int i = 0; i < 6; i++) begin
      alloc_pd_old = 7'(i);
      tick();
    end
    mispredict = 1; mispredict_tag = 4'd2;
    mem_done = 1; mem_tag = 4'd4;
    #1 check("mp_blocks_alloc", alloc_ready, 0);
    tick(); mispredict = 0; mem_done = 0; alloc_valid = 0;
    #1 check("mp_count", count, 3);
    check("mp_tail", alloc_tag, 3);
    mem_done = 1; mem_tag = 4'd4;
    tick(); mem_done = 0;
    #1 check("mp_ignored_count", count, 3);
    check("mp_no_retire", retire_valid, 0);
    mispredict = 1; mispredict_tag = 4'd10; alloc_valid = 1;
    #1 check("mp_inv_blocks", alloc_ready, 0);
    tick(); mispredict = 0; alloc_valid = 0;
    #1 check("mp_inv_count", count, 3);
    check("mp_inv_tail", alloc_tag, 3);
    alloc_valid = 1;
    tick(); alloc_valid = 0;
    #1 check("mp_realloc_count", count, 4);
    check("mp_realloc_tail", alloc_tag, 4);

    // alloc + complete + mispredict on head in one cycle
    pulse_reset();
    alloc_valid = 1;
    for (int i = 0; i < 3; i++) begin
      alloc_pd_old = 7'(30 + i);
      tick();
    end
    alu_done = 1; alu_tag = 4'd0;
    mispredict = 1; mispredict_tag = 4'd0; alloc_pd_old = 7'd33;
    #1 check("same_blocks", alloc_ready, 0);
    tick(); alu_done = 0; mispredict = 0;
    #1 check("same_count", count, 1);
    check("same_tail", alloc_tag, 1);
    check("same_retire_valid", retire_valid, 1);
    check("same_retire_tag", retire_tag, 0);
    check("same_retire_pd", retire_pd_old, 30);
    tick(); alloc_valid = 0;
    #1 check("alloc_retire_count", count, 1);
    check("alloc_retire_tail", alloc_tag, 2);
    check("alloc_retire_head", curr_rob_tag, 1);
    check("alloc_retire_valid", retire_valid, 0);

    // reset mid-operation
    alloc_valid = 1;
    for (int i = 0; i < 6; i++) begin
      alloc_pd_old = 7'(50 + i);
      tick();
    end
    alloc_valid = 0;
    alu_done = 1; alu_tag = 4'd1;
    tick(); alu_done = 0;
    #1 check("pre_rst_count", count, 7);
    check("pre_rst_retire", retire_valid, 1);
    reset = 1;
    #1 check("mid_rst_count", count, 0);
    check("mid_rst_retire", retire_valid, 0);
    check("mid_rst_ready", alloc_ready, 0);
    check("mid_rst_head", curr_rob_tag, 0);
    reset = 0; alloc_valid = 1;
    #1 check("post_rst_tag", alloc_tag, 0);
    check("post_rst_ready", alloc_ready, 1);
    tick(); alloc_valid = 0;
    #1 check("post_rst_count", count, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rob.md
ROB -- requirements
Module: rob

Interface
REQ-001 Parameter DEPTH, default 16; number of ROB entries, a power of two.
REQ-002 Parameter TAG_W, default 4; tag width, log2(DEPTH).
REQ-003 Parameter PREG_W, default 7; physical register index width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 alloc_valid  input  1  dispatch presents an instruction for allocation.
REQ-007 alloc_has_rd  input  1  instruction writes a destination register.
REQ-008 alloc_pd_old  input  PREG_W  previous physical mapping of rd, to be freed at retire.
REQ-009 alloc_ready  output  1  ROB can accept an allocation this cycle.
REQ-010 alloc_tag  output  TAG_W  tag assigned to the allocating instruction (current tail).
REQ-011 alu_done, b_done, mem_done  input  1 each  FU completion strobes.
REQ-012 alu_tag, b_tag, mem_tag  input  TAG_W each  ROB tag of the completing instruction.
REQ-013 mispredict  input  1  branch unit reports a mispredicted branch.
REQ-014 mispredict_tag  input  TAG_W  ROB tag of the mispredicted branch.
REQ-015 retire_valid  output  1  head instruction retires this cycle.
REQ-016 retire_tag  output  TAG_W  tag of the retiring instruction.
REQ-017 retire_has_rd  output  1  retiring instruction frees retire_pd_old.
REQ-018 retire_pd_old  output  PREG_W  physical register returned to the free list.
REQ-019 curr_rob_tag  output  TAG_W  head pointer (oldest in-flight tag).
REQ-020 count  output  TAG_W+1  number of valid entries, 0..DEPTH.

Function
REQ-021 Per entry: valid, done, has_rd, pd_old; head, tail pointers TAG_W wide, wrap DEPTH-1 -> 0 modulo DEPTH.
REQ-022 alloc_ready = (count < DEPTH) and not mispredict; combinational; not relaxed by a same-cycle retire.
REQ-023 Allocation when alloc_valid and alloc_ready: entry[tail] <= {valid=1, done=0, has_rd, pd_old}; tail <= tail+1; alloc_tag equals pre-increment tail.
REQ-024 Completion on any strobe: entry[tag].done <= 1 only if entry[tag].valid; strobes to invalid entries are ignored; up to three distinct-tag completions per cycle.
REQ-025 retire_valid = entry[head].valid and entry[head].done, combinational from registered state; retire_tag/has_rd/pd_old from entry[head]; outputs 0 when retire_valid=0.
REQ-026 On retire: entry[head].valid <= 0, head <= head+1; at most one retire per cycle.
REQ-027 Completion of the head entry in cycle N yields retire_valid in cycle N+1 (one-cycle minimum completion-to-retire latency).
REQ-028 Mispredict (mispredict=1 and entry[mispredict_tag].valid): all entries strictly younger than mispredict_tag invalidated; tail <= mispredict_tag+1; branch entry itself retained.
REQ-029 Mispredict with entry[mispredict_tag].valid=0: ignored, except that allocation is still blocked that cycle.
REQ-030 Mispredict cycle: completions to flushed entries discarded; completions to retained entries applied; head retire proceeds normally.
REQ-031 count update: no flush -> count + alloc - retire; flush -> ((mispredict_tag - head) mod DEPTH) + 1 - retire.
REQ-032 Full (count=DEPTH, head=tail): distinguished from empty by count only, never by pointer equality.
REQ-033 Simultaneous allocation and retire at count in 1..DEPTH-1: both occur, count unchanged.

Reset
REQ-034 On reset assertion, immediately and without clk: head=0, tail=0, count=0, all valid/done=0.
REQ-035 During reset: alloc_ready=0, retire_valid=0, alloc_tag=0, curr_rob_tag=0, retire_tag=0, retire_has_rd=0, retire_pd_old=0.
REQ-036 Reset asserted mid-operation discards all in-flight entries; first post-reset allocation receives tag 0.

Verification
REQ-037 Allocate 3 (pd_old 10,11,12, has_rd=1) -> tags 0,1,2, count=3; complete tag 0 -> next cycle retire_valid=1, retire_pd_old=10.
REQ-038 Complete tags 2 then 1 out of order, tag 0 last -> retires tag 0,1,2 on three consecutive cycles, in order.
REQ-039 Allocate 16 -> count=16, alloc_ready=0; retire one -> alloc_ready=1 next cycle; next alloc_tag=0 (wrap).
REQ-040 head=0, tags 0..5 valid, mispredict with tag 2 -> tail=3, count=3, later mem_done tag 4 ignored, next alloc_tag=3.
REQ-041 Same cycle: alloc_valid=1, alu_done tag 0 (head), mispredict tag 0 -> no allocation, entry 0 done, tail=1, count=1; retire tag 0 next cycle.
REQ-042 Assert reset with count=7 -> count=0, retire_valid=0 immediately; deassert, allocate -> alloc_tag=0.
